// File: rtl/zoom_sequencer_if.sv
// Frame-control bus between zoom_sequencer (master) and the scheduler/display side (slave).
interface zoom_sequencer_if #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 16
);
  logic              pause;
  logic              frame_busy;
  logic              frame_done;
  logic              disp_frame_done;
  logic              frame_start;
  logic [WIDTH-1:0]  c_re_start;
  logic [WIDTH-1:0]  c_im_start;
  logic [WIDTH-1:0]  step;
  logic [ITER_W-1:0] max_iter;
  logic              zoom_out;
  logic [15:0]       frame_count;

  modport master (
    input  pause, frame_busy, frame_done, disp_frame_done,
    output frame_start, c_re_start, c_im_start, step, max_iter, zoom_out, frame_count
  );

  modport slave (
    output pause, frame_busy, frame_done, disp_frame_done,
    input  frame_start, c_re_start, c_im_start, step, max_iter, zoom_out, frame_count
  );
endinterface

// File: rtl/zoom_sequencer.sv
// Frame-level zoom controller: issues frame_start, then computes the next viewport serially.
// Optional macro ZOOM_BOUNCE_EN: reverse into zoom-out at the depth limit instead of restarting.
module zoom_sequencer #(
  parameter int               WIDTH         = 32,
  parameter int               ITER_W        = 16,
  parameter int               H_RES         = 320,
  parameter int               V_RES         = 172,
  parameter logic [WIDTH-1:0] INIT_STEP     = 32'h0026_6666,
  parameter logic [WIDTH-1:0] TARGET_RE     = 32'hF414_7AE1,
  parameter logic [WIDTH-1:0] TARGET_IM     = 32'h01CF_DF3B,
  parameter int               ZOOM_SHIFT    = 6,
  parameter logic [WIDTH-1:0] MIN_STEP      = 32'h0000_0010,
  parameter int               MAX_ITER_INIT = 256,
  parameter int               MAX_ITER_CAP  = 1024,
  parameter int               ITER_INC      = 1
) (
  input logic             clk,
  input logic             rst_n_in,
  zoom_sequencer_if.master bus
);

  localparam logic [8:0]        MUL_H   = 9'(H_RES / 2);
  localparam logic [8:0]        MUL_V   = 9'(V_RES / 2);
  localparam logic [WIDTH-1:0]  RE0     = TARGET_RE - WIDTH'((H_RES / 2) * INIT_STEP);
  localparam logic [WIDTH-1:0]  IM0     = TARGET_IM - WIDTH'((V_RES / 2) * INIT_STEP);
  localparam logic [ITER_W-1:0] IT_INIT = ITER_W'(MAX_ITER_INIT);
  localparam logic [ITER_W-1:0] IT_CAP  = ITER_W'(MAX_ITER_CAP);
  localparam logic [ITER_W-1:0] IT_INC  = ITER_W'(ITER_INC);

  typedef enum logic [2:0] {BOOT, START, RUN, CALC, SYNC} state_t;

  state_t            state, state_nx;
  logic              start_o, accept, commit;
  logic [3:0]        cnt;
  logic [WIDTH-1:0]  acc_h, acc_v, mcand;
  logic              disp_seen;
  logic [WIDTH-1:0]  step_q, re_q, im_q;
  logic [ITER_W-1:0] iter_q;
  logic              zoom_q;
  logic [15:0]       fcnt_q;

  logic [WIDTH-1:0]  delta, next_step, next_delta;
  logic              lim_in, clamp;
  logic [ITER_W-1:0] iter_up, iter_dn;

  always_ff @(posedge clk or negedge rst_n_in)
    if (!rst_n_in) state <= BOOT;
    else           state <= state_nx;

  always_comb begin
    state_nx = state;
    start_o  = 1'b0;
    accept   = 1'b0;
    commit   = 1'b0;
    case (state)
      BOOT:  state_nx = START;
      START: begin start_o = 1'b1; state_nx = RUN; end
      RUN:   if (bus.frame_done && !bus.frame_busy) begin accept = 1'b1; state_nx = CALC; end
      CALC:  if (cnt == 4'd8) state_nx = SYNC;
      SYNC:  if (disp_seen && !bus.pause) begin commit = 1'b1; state_nx = START; end
      default: state_nx = BOOT;
    endcase
  end

  // step is frozen until commit, so next_step is stable for the whole multiply
  assign delta      = $signed(step_q) >>> ZOOM_SHIFT;
  assign next_step  = zoom_q ? step_q + delta : step_q - delta;
  assign next_delta = $signed(next_step) >>> ZOOM_SHIFT;
  // also limited once the following step could no longer move, so a reversal can still grow
  assign lim_in     = !zoom_q && (($signed(next_step) < $signed(MIN_STEP)) || (next_delta == '0));
  assign clamp      = zoom_q && ($signed(next_step) >= $signed(INIT_STEP));
  assign iter_up    = (iter_q >= IT_CAP - IT_INC)  ? IT_CAP  : iter_q + IT_INC;
  assign iter_dn    = (iter_q <= IT_INIT + IT_INC) ? IT_INIT : iter_q - IT_INC;

  always_ff @(posedge clk or negedge rst_n_in)
    if (!rst_n_in) begin
      cnt       <= '0;
      acc_h     <= '0;
      acc_v     <= '0;
      mcand     <= '0;
      disp_seen <= 1'b1;
      step_q    <= INIT_STEP;
      re_q      <= RE0;
      im_q      <= IM0;
      iter_q    <= IT_INIT;
      zoom_q    <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      if (bus.disp_frame_done)  disp_seen <= 1'b1;
      else if (state == START)  disp_seen <= 1'b0;

      // serial shift-add, LSB of the constant multiplier first
      if (accept) begin
        fcnt_q <= fcnt_q + 16'd1;
        cnt    <= '0;
        acc_h  <= '0;
        acc_v  <= '0;
        mcand  <= next_step;
      end else if (state == CALC) begin
        if (MUL_H[cnt]) acc_h <= acc_h + mcand;
        if (MUL_V[cnt]) acc_v <= acc_v + mcand;
        mcand <= mcand << 1;
        cnt   <= cnt + 4'd1;
      end

      if (commit) begin
        if (lim_in) begin
`ifdef ZOOM_BOUNCE_EN
          zoom_q <= 1'b1;
`else
          step_q <= INIT_STEP;
          re_q   <= RE0;
          im_q   <= IM0;
          iter_q <= IT_INIT;
`endif
        end else if (clamp) begin
          step_q <= INIT_STEP;
          re_q   <= RE0;
          im_q   <= IM0;
          zoom_q <= 1'b0;
          iter_q <= iter_dn;
        end else begin
          step_q <= next_step;
          re_q   <= TARGET_RE - acc_h;
          im_q   <= TARGET_IM - acc_v;
          iter_q <= zoom_q ? iter_dn : iter_up;
        end
      end
    end

  assign bus.frame_start = start_o;
  assign bus.c_re_start  = re_q;
  assign bus.c_im_start  = im_q;
  assign bus.step        = step_q;
  assign bus.max_iter    = iter_q;
  assign bus.zoom_out    = zoom_q;
  assign bus.frame_count = fcnt_q;

endmodule
